// File: rtl/branch_resolve_unit_if.sv
// Bus between IF/ID pipeline control and the branch resolve unit.
// The master drives fetch/ID inputs; the slave returns resolution and statistics.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             if_branch;
  logic             if_bne;
  logic [31:0]      if_pc;
  logic [31:0]      if_imm;
  logic             pred_taken;
  logic [31:0]      id_rs1_data;
  logic [31:0]      id_rs2_data;
  logic             resolve_valid;
  logic             actual_taken;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic             flush_if;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stall, if_branch, if_bne, if_pc, if_imm, pred_taken, id_rs1_data, id_rs2_data,
    input  resolve_valid, actual_taken, mispredict, redirect_pc, flush_if, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall, if_branch, if_bne, if_pc, if_imm, pred_taken, id_rs1_data, id_rs2_data,
    output resolve_valid, actual_taken, mispredict, redirect_pc, flush_if, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage BEQ/BNE resolution: captures IF branch + prediction, resolves in ID, redirects on mispredict.
// Statistics counters are built only when BRRES_STATS_EN is defined; otherwise they read 0.
module branch_resolve_unit #(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);
  typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_vld_p1, r_bne_p1, r_pred_p1;
  logic [31:0] r_pc4_p1, r_tgt_p1;
  logic        w_eq, w_taken, w_resolve, w_mispredict, w_capture;
  logic [31:0] w_redirect;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_eq         = (bus.id_rs1_data == bus.id_rs2_data);
    w_taken      = w_eq ^ r_bne_p1;
    // Outputs are forced quiet while reset is asserted so a resolve-cycle reset emits no pulses.
    w_resolve    = rst_n && !bus.stall && r_vld_p1 && (r_state == RUN);
    w_mispredict = w_resolve && (w_taken != r_pred_p1);
    w_redirect   = w_mispredict ? (w_taken ? r_tgt_p1 : r_pc4_p1) : 32'd0;
    unique case (r_state)
      RUN:     if (w_mispredict) w_state_nxt = SQUASH;
      SQUASH:  if (!bus.stall)   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
    // A branch fetched behind a mispredict or during squash is wrong-path and never captured.
    w_capture    = !bus.stall && bus.if_branch && (r_state == RUN) && !w_mispredict;
  end

  assign bus.resolve_valid = w_resolve;
  assign bus.actual_taken  = w_resolve & w_taken;
  assign bus.mispredict    = w_mispredict;
  assign bus.flush_if      = w_mispredict;
  assign bus.redirect_pc   = w_redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  // IF -> ID stage boundary
  always_ff @(posedge clk) begin
    if (!rst_n)          r_vld_p1 <= 1'b0;
    else if (!bus.stall) r_vld_p1 <= w_capture;
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_bne_p1  <= bus.if_bne;
      r_pred_p1 <= bus.pred_taken;
      r_pc4_p1  <= bus.if_pc + 32'd4;
      r_tgt_p1  <= bus.if_pc + bus.if_imm;
    end
  end

`ifdef BRRES_STATS_EN
  logic [CNT_W-1:0] r_branch_cnt, r_mispred_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_branch_cnt  <= sat_inc(r_branch_cnt, w_resolve);
      r_mispred_cnt <= sat_inc(r_mispred_cnt, w_mispredict);
    end
  end

  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;
`else
  assign bus.branch_cnt  = '0;
  assign bus.mispred_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios plus randomized traffic vs a branch-level model.
module tb_branch_resolve_unit;
  localparam int CW = 4;

  typedef struct {
    logic          rv, at, mp, fl;
    logic [31:0]   rpc;
    logic [CW-1:0] bc, mc;
  } exp_t;

  typedef struct {
    bit          bne, pred;
    logic [31:0] pc, imm;
  } br_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.CNT_W(CW)) bus ();
  branch_resolve_unit #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  exp_t sbq[$];
  br_t  pend[$];
  bit   squash;
  int   nb, nm;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [CW-1:0] sat(input int n);
    return (n > (2**CW - 1)) ? CW'(2**CW - 1) : CW'(n);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // One clock cycle of stimulus; the expectation for this cycle is queued, then the model advances.
  task automatic cyc(input bit rn, input bit st, input bit br, input bit bne,
                     input logic [31:0] pc, input logic [31:0] imm, input bit pr,
                     input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    br_t  p;
    bit   was_sq;
    @(posedge clk); #1;
    rst_n = rn; bus.stall = st; bus.if_branch = br; bus.if_bne = bne;
    bus.if_pc = pc; bus.if_imm = imm; bus.pred_taken = pr;
    bus.id_rs1_data = a; bus.id_rs2_data = b;
    e.rv = 0; e.at = 0; e.mp = 0; e.fl = 0; e.rpc = 32'd0;
    if (rn && !st && !squash && pend.size() > 0) begin
      p = pend[0];
      e.rv = 1;
      e.at = (a == b) ? !p.bne : p.bne;
      e.mp = (e.at != p.pred);
      e.fl = e.mp;
      if (e.mp) e.rpc = e.at ? (p.pc + p.imm) : (p.pc + 32'd4);
    end
`ifdef BRRES_STATS_EN
    e.bc = sat(nb); e.mc = sat(nm);
`else
    e.bc = '0; e.mc = '0;
`endif
    sbq.push_back(e);
    if (!rn) begin
      pend.delete(); squash = 0; nb = 0; nm = 0;
    end else if (!st) begin
      was_sq = squash;
      if (e.rv) begin nb++; if (e.mp) nm++; end
      pend.delete();
      squash = e.mp;
      if (br && !e.mp && !was_sq) begin
        p.bne = bne; p.pred = pr; p.pc = pc; p.imm = imm;
        pend.push_back(p);
      end
    end
  endtask

  task automatic idle(input logic [31:0] a, input logic [31:0] b);
    cyc(1, 0, 0, 0, 32'd0, 32'd0, 0, a, b);
  endtask

  task automatic rst_cyc();
    cyc(0, 0, 0, 0, 32'd0, 32'd0, 0, 32'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("resolve_valid", 32'(bus.resolve_valid), 32'(e.rv));
      chk("actual_taken",  32'(bus.actual_taken),  32'(e.at));
      chk("mispredict",    32'(bus.mispredict),    32'(e.mp));
      chk("flush_if",      32'(bus.flush_if),      32'(e.fl));
      chk("redirect_pc",   bus.redirect_pc,        e.rpc);
      chk("branch_cnt",    32'(bus.branch_cnt),    32'(e.bc));
      chk("mispred_cnt",   32'(bus.mispred_cnt),   32'(e.mc));
    end
  end

  initial begin
    logic [31:0] r;
    rst_n = 0; bus.stall = 0; bus.if_branch = 0; bus.if_bne = 0; bus.if_pc = 0;
    bus.if_imm = 0; bus.pred_taken = 0; bus.id_rs1_data = 0; bus.id_rs2_data = 0;
    squash = 0; nb = 0; nm = 0;
    @(posedge clk);
    rst_cyc(); rst_cyc();

    // BEQ taken, predicted taken
    cyc(1, 0, 1, 0, 32'h40, 32'h10, 1, 0, 0);
    idle(32'd5, 32'd5);
    // BNE predicted taken but not taken; wrong-path branches that follow are dropped
    cyc(1, 0, 1, 1, 32'h80, 32'h20, 1, 0, 0);
    cyc(1, 0, 1, 0, 32'h200, 32'h8, 1, 32'd7, 32'd7);
    cyc(1, 0, 1, 0, 32'h204, 32'h8, 1, 32'd1, 32'd1);
    idle(32'd1, 32'd1);
    idle(32'd1, 32'd1);
    // BEQ backward, predicted not taken
    cyc(1, 0, 1, 0, 32'h100, 32'hFFFF_FFF8, 0, 0, 0);
    idle(32'd3, 32'd3);
    idle(0, 0);

    // Three back-to-back correctly predicted BEQs
    rst_cyc();
    cyc(1, 0, 1, 0, 32'h10, 32'h40, 1, 0, 0);
    cyc(1, 0, 1, 0, 32'h14, 32'h40, 1, 32'd9, 32'd9);
    cyc(1, 0, 1, 0, 32'h18, 32'h40, 1, 32'd9, 32'd9);
    idle(32'd9, 32'd9);
    idle(0, 1);

    // Stall holds a captured branch, then resolves
    cyc(1, 0, 1, 1, 32'h300, 32'h40, 0, 0, 0);
    cyc(1, 1, 1, 0, 32'h304, 32'h4, 1, 32'd2, 32'd3);
    cyc(1, 1, 1, 0, 32'h304, 32'h4, 1, 32'd2, 32'd3);
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'd2, 32'd3);
    idle(0, 0);
    // Reset in the resolve cycle
    cyc(1, 0, 1, 0, 32'h400, 32'h40, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h404, 32'h40, 0, 32'd4, 32'd4);
    idle(32'd4, 32'd4);
    idle(0, 0);

    // Counter saturation with mispredicts
    rst_cyc();
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 1, 0, 32'h500 + 32'(i * 4), 32'h80, 0, 0, 0);
      idle(32'd6, 32'd6);
      idle(0, 0);
    end
    idle(0, 0);

    // Randomized traffic
    rst_cyc();
    for (int i = 0; i < 2500; i++) begin
      r = $urandom;
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) < 6), r[0], $urandom, $urandom, r[1],
          {29'd0, r[4:2]}, {29'd0, r[4:3], r[5] & r[6]});
    end
    idle(0, 0);

    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch resolution block for the 5-stage core, the consumer side of the 2-bit direction predictor. It captures each conditional branch fetched in IF together with the predictor's guess. One cycle later, in ID, it compares the register operands to find the real outcome. It drives the outcome back to the predictor, and on a wrong guess it redirects fetch and squashes the wrong-path instruction.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `stall` input 1: pipeline stall; freezes all state in this block.
- `if_branch` input 1: the IF instruction is BEQ or BNE.
- `if_bne` input 1: the IF branch is BNE (0 means BEQ).
- `if_pc` input 32: PC of the IF instruction.
- `if_imm` input 32: sign-extended, already-shifted branch offset.
- `pred_taken` input 1: predictor's direction guess for the IF branch.
- `id_rs1_data` input 32: forwarded rs1 value in ID.
- `id_rs2_data` input 32: forwarded rs2 value in ID.
- `resolve_valid` output 1: a branch resolves in ID this cycle (predictor update strobe).
- `actual_taken` output 1: resolved direction; valid only when `resolve_valid`=1.
- `mispredict` output 1: resolved direction differs from the captured prediction.
- `redirect_pc` output 32: corrected fetch PC; valid only when `mispredict`=1.
- `flush_if` output 1: squash the IF/ID register contents next edge.
- `branch_cnt` output CNT_W: number of resolved branches.
- `mispred_cnt` output CNT_W: number of mispredictions.

## Operation
- Entry register holds: `v`, `bne`, `pred`, `pc4` (= if_pc+4, 32-bit wrap), `tgt` (= if_pc+if_imm, 32-bit wrap).
- Capture rule: on an edge with `stall`=0, the entry loads the IF signals when `if_branch`=1 and the block is not squashing. Otherwise `v` is cleared. A new capture and a resolution can happen in the same cycle; back-to-back branches are allowed.
- Resolution is combinational from the entry and the ID operands. When `v`=1 and `stall`=0:
  - `eq` = (rs1 == rs2).
  - `actual_taken` = `eq` XOR `bne`.
  - `resolve_valid` = 1.
  - `mispredict` = `actual_taken` != `pred`.
  - `redirect_pc` = `tgt` if `actual_taken`, else `pc4`.
- FSM with states RUN and SQUASH; reset state is RUN.
  - RUN → SQUASH when `mispredict`=1. `flush_if`=1 in the same cycle.
  - In SQUASH, `if_branch` is ignored: the instruction in IF is wrong-path and is not captured. `resolve_valid`=0.
  - SQUASH → RUN on the next edge with `stall`=0.
  - While `stall`=1 the FSM holds its state.
- A mispredicting resolution blocks capture of the IF branch in the same cycle, because that branch is on the wrong path.
- `stall`=1 freezes everything:
  - The entry, FSM and counters hold.
  - `resolve_valid`, `mispredict` and `flush_if` are 0.
- `redirect_pc` is 0 whenever `mispredict`=0.

## Timing
- Capture happens at IF edge N. The branch resolves combinationally during cycle N+1. The predictor sees `resolve_valid` in that same cycle.
- Misprediction penalty is one squashed instruction:
  - Redirect fetch occurs in cycle N+1.
  - Correct-path fetch happens at edge N+2.
- `mispredict` and `flush_if` are single-cycle pulses, stretched only if the condition persists without a stall.
- Reset values:
  - All outputs 0, counters 0, entry `v`=0, FSM in RUN.
  - Reset asserted mid-resolution discards the entry with no pulses on the following cycle.
- Counters:
  - Increment on edges where `resolve_valid`=1 (`mispred_cnt` only when `mispredict` is also 1).
  - They saturate at 2^CNT_W−1 and do not wrap.

## Configuration
- `BRRES_STATS_EN` defined: `branch_cnt` and `mispred_cnt` are implemented as above.
- `BRRES_STATS_EN` undefined: no counter flops; both outputs are tied to 0. All other behaviour is identical.

## Test plan
- BEQ at pc=0x40, imm=0x10, pred=1, rs1=rs2=5. Required: `resolve_valid`=1, `actual_taken`=1, `mispredict`=0, `flush_if`=0.
- BNE at pc=0x80, imm=0x20, pred=1, rs1=rs2=7. Required: `actual_taken`=0, `mispredict`=1, `redirect_pc`=0x84, `flush_if`=1. In the next cycle, an IF branch is ignored (no resolve two cycles later).
- BEQ at pc=0x100, imm=−8, pred=0, rs1=rs2. Required: `mispredict`=1, `redirect_pc`=0xF8.
- Three back-to-back correctly predicted BEQs. Required: `resolve_valid` high in 3 consecutive cycles, `branch_cnt`=3, `mispred_cnt`=0.
- Branch captured, then `stall`=1 for 2 cycles. Required: no pulses while stalled; resolution occurs in the first unstalled cycle with the values held. Separately, `rst_n`=0 asserted in the resolve cycle clears everything.
- CNT_W=4, 20 mispredicting branches with stats enabled. Required: both counters hold 15. With `BRRES_STATS_EN` undefined, both read 0.
